// File: rtl/icache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : icache_port_arbiter
// Brief    : Round-robin arbiter that shares one I-cache fetch port among
//            NUM_SM Fetch units. Optional macro ICACHE_ARB_B2B_EN enables
//            back-to-back issue, so there is no IDLE bubble between grants.
// Revision : 1.0
// ============================================================================
module icache_port_arbiter #(
  parameter int NUM_SM           = 4,
  parameter int NUM_SM_LOG       = 2,
  parameter int SIZE_PC          = 32,
  parameter int SIZE_INSTRUCTION = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SM-1:0]             fetchReq_i,
  input  logic [NUM_SM*SIZE_PC-1:0]     fetchPC_i,
  input  logic [NUM_SM-1:0]             flush_i,
  output logic [NUM_SM-1:0]             grant_o,
  output logic [NUM_SM-1:0]             fetchValid_o,
  output logic [SIZE_INSTRUCTION-1:0]   instruction0_o,
  output logic [SIZE_INSTRUCTION-1:0]   instruction1_o,
  output logic                          cacheReq_o,
  output logic [SIZE_PC-1:0]            PC_o,
  output logic [SIZE_PC-1:0]            PCadd1_o,
  input  logic                          cacheAck_i,
  input  logic                          cacheValid_i,
  input  logic [SIZE_INSTRUCTION-1:0]   instruction0_i,
  input  logic [SIZE_INSTRUCTION-1:0]   instruction1_i,
  output logic                          busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [NUM_SM_LOG-1:0]       rrPtr_q, rrPtr_d;
  logic [NUM_SM_LOG-1:0]       winner_q, winner_d;
  logic [SIZE_PC-1:0]          pc_q, pc_d;
  logic [SIZE_PC-1:0]          pcAdd1_q, pcAdd1_d;
  logic                        dropped_q, dropped_d;
  logic [NUM_SM-1:0]           grant_q, grant_d;
  logic [NUM_SM-1:0]           fetchValid_q, fetchValid_d;
  logic [SIZE_INSTRUCTION-1:0] instr0_q, instr0_d;
  logic [SIZE_INSTRUCTION-1:0] instr1_q, instr1_d;

  logic [SIZE_PC-1:0]          pcArr_w [NUM_SM];
  logic [NUM_SM-1:0]           eligible_w;
  logic [NUM_SM-1:0]           winnerOneHot_w;
  logic                        flushWinner_w;
  logic [NUM_SM_LOG-1:0]       arbBase_w;
  logic [NUM_SM-1:0]           arbReq_w;
  logic [NUM_SM_LOG:0]         arbResult_w;
  logic                        arbFound_w;
  logic [NUM_SM_LOG-1:0]       arbIdx_w;

  genvar k;
  generate
    for (k = 0; k < NUM_SM; k++) begin : g_pc_unpack
      assign pcArr_w[k] = fetchPC_i[k*SIZE_PC +: SIZE_PC];
    end
  endgenerate

  // First requester at or after base, modulo NUM_SM; MSB flags a hit.
  function automatic logic [NUM_SM_LOG:0] rr_pick(
    input logic [NUM_SM_LOG-1:0] base,
    input logic [NUM_SM-1:0]     req
  );
    logic [NUM_SM_LOG:0]   res;
    logic [NUM_SM_LOG-1:0] idx;
    res = '0;
    for (int i = NUM_SM - 1; i >= 0; i--) begin
      idx = base + NUM_SM_LOG'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign eligible_w     = fetchReq_i & ~flush_i;
  assign winnerOneHot_w = NUM_SM'(1) << winner_q;
  assign flushWinner_w  = flush_i[winner_q];

`ifdef ICACHE_ARB_B2B_EN
  // In WAIT the next winner is picked from winner+1, excluding the SM being served.
  assign arbBase_w = (state_q == S_WAIT) ? (winner_q + NUM_SM_LOG'(1)) : rrPtr_q;
  assign arbReq_w  = (state_q == S_WAIT) ? (eligible_w & ~winnerOneHot_w) : eligible_w;
`else
  assign arbBase_w = rrPtr_q;
  assign arbReq_w  = eligible_w;
`endif

  assign arbResult_w = rr_pick(arbBase_w, arbReq_w);
  assign arbFound_w  = arbResult_w[NUM_SM_LOG];
  assign arbIdx_w    = arbResult_w[NUM_SM_LOG-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrPtr_q      <= '0;
      winner_q     <= '0;
      pc_q         <= '0;
      pcAdd1_q     <= '0;
      dropped_q    <= 1'b0;
      grant_q      <= '0;
      fetchValid_q <= '0;
      instr0_q     <= '0;
      instr1_q     <= '0;
    end else begin
      rrPtr_q      <= rrPtr_d;
      winner_q     <= winner_d;
      pc_q         <= pc_d;
      pcAdd1_q     <= pcAdd1_d;
      dropped_q    <= dropped_d;
      grant_q      <= grant_d;
      fetchValid_q <= fetchValid_d;
      instr0_q     <= instr0_d;
      instr1_q     <= instr1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rrPtr_d      = rrPtr_q;
    winner_d     = winner_q;
    pc_d         = pc_q;
    pcAdd1_d     = pcAdd1_q;
    dropped_d    = dropped_q;
    grant_d      = grant_q;
    fetchValid_d = '0;
    instr0_d     = instr0_q;
    instr1_d     = instr1_q;
    case (state_q)
      S_IDLE: begin
        if (arbFound_w) begin
          state_d   = S_ISSUE;
          winner_d  = arbIdx_w;
          pc_d      = pcArr_w[arbIdx_w];
          pcAdd1_d  = pcArr_w[arbIdx_w] + SIZE_PC'(1);
          grant_d   = NUM_SM'(1) << arbIdx_w;
          dropped_d = 1'b0;
        end
      end
      S_ISSUE: begin
        if (cacheAck_i) begin
          state_d   = S_WAIT;
          dropped_d = flushWinner_w;
        end else if (flushWinner_w) begin
          state_d = S_IDLE;
          grant_d = '0;
          rrPtr_d = winner_q + NUM_SM_LOG'(1);
        end
      end
      S_WAIT: begin
        if (cacheValid_i) begin
          instr0_d = instruction0_i;
          instr1_d = instruction1_i;
          // A flush arriving with the data still suppresses delivery.
          if (!dropped_q && !flushWinner_w) fetchValid_d = winnerOneHot_w;
          rrPtr_d   = winner_q + NUM_SM_LOG'(1);
          grant_d   = '0;
          dropped_d = 1'b0;
          state_d   = S_IDLE;
`ifdef ICACHE_ARB_B2B_EN
          if (arbFound_w) begin
            state_d   = S_ISSUE;
            winner_d  = arbIdx_w;
            pc_d      = pcArr_w[arbIdx_w];
            pcAdd1_d  = pcArr_w[arbIdx_w] + SIZE_PC'(1);
            grant_d   = NUM_SM'(1) << arbIdx_w;
          end
`endif
        end else if (flushWinner_w) begin
          dropped_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    grant_o        = grant_q;
    fetchValid_o   = fetchValid_q;
    instruction0_o = instr0_q;
    instruction1_o = instr1_q;
    PC_o           = pc_q;
    PCadd1_o       = pcAdd1_q;
    cacheReq_o     = (state_q == S_ISSUE);
    busy_o         = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_port_arbiter.sv
`default_nettype none
// Testbench for icache_port_arbiter: directed scenarios followed by random
// traffic, compared cycle by cycle against a transaction-level reference model.
module tb_icache_port_arbiter;
  localparam int N  = 4;
  localparam int LG = 2;
  localparam int PW = 32;
  localparam int IW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  fetchReq, flush, grant, fv;
  logic [N*PW-1:0] fetchPC;
  logic [IW-1:0] i0o, i1o, i0i, i1i;
  logic          cacheReq, cacheAck, cacheValid, busy;
  logic [PW-1:0] PCo, PC1o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one transaction in flight, tracked as owner + progress flags.
  bit            m_busy, m_acked, m_drop;
  int            m_win, m_ptr;
  logic [PW-1:0] m_pc, m_pc1;
  logic [N-1:0]  m_fv;
  logic [IW-1:0] m_i0, m_i1;

  icache_port_arbiter #(.NUM_SM(N), .NUM_SM_LOG(LG), .SIZE_PC(PW), .SIZE_INSTRUCTION(IW)) dut (
    .clk(clk), .reset(reset),
    .fetchReq_i(fetchReq), .fetchPC_i(fetchPC), .flush_i(flush),
    .grant_o(grant), .fetchValid_o(fv),
    .instruction0_o(i0o), .instruction1_o(i1o),
    .cacheReq_o(cacheReq), .PC_o(PCo), .PCadd1_o(PC1o),
    .cacheAck_i(cacheAck), .cacheValid_i(cacheValid),
    .instruction0_i(i0i), .instruction1_i(i1i),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int ptr, input logic [N-1:0] e);
    for (int j = 0; j < N; j++) if (e[(ptr + j) % N]) return (ptr + j) % N;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_acked = 0; m_drop = 0; m_win = 0; m_ptr = 0;
    m_pc = '0; m_pc1 = '0; m_fv = '0; m_i0 = '0; m_i1 = '0;
  endtask

  task automatic grant_to(input int w);
    m_win = w; m_busy = 1; m_acked = 0; m_drop = 0;
    m_pc  = fetchPC[w*PW +: PW];
    m_pc1 = m_pc + 32'd1;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    logic [N-1:0] e;
    logic [N-1:0] nfv;
    int w;
    e = fetchReq & ~flush;
    nfv = '0;
    w = m_win;
    if (!m_busy) begin
      if (e != 0) grant_to(pick(m_ptr, e));
    end else if (!m_acked) begin
      if (cacheAck) begin
        m_acked = 1; m_drop = flush[w];
      end else if (flush[w]) begin
        m_busy = 0; m_ptr = (w + 1) % N;
      end
    end else if (cacheValid) begin
      m_i0 = i0i; m_i1 = i1i;
      if (!m_drop && !flush[w]) nfv[w] = 1'b1;
      m_busy = 0; m_ptr = (w + 1) % N;
`ifdef ICACHE_ARB_B2B_EN
      e[w] = 1'b0;
      if (e != 0) grant_to(pick(m_ptr, e));
`endif
    end else if (flush[w]) begin
      m_drop = 1;
    end
    m_fv = nfv;
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = m_busy ? (N'(1) << m_win) : '0;
    chk("grant", grant, eg);
    chk("cacheReq", cacheReq, m_busy && !m_acked);
    chk("busy", busy, m_busy);
    chk("PC", PCo, m_pc);
    chk("PCadd1", PC1o, m_pc1);
    chk("fetchValid", fv, m_fv);
    if (m_fv != 0) begin
      chk("instr0", i0o, m_i0);
      chk("instr1", i1o, m_i1);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_fv"}, fv, 0);
    chk({tag, "_req"}, cacheReq, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pc"}, PCo, 0);
    chk({tag, "_pc1"}, PC1o, 0);
    chk({tag, "_i0"}, i0o, 0);
    chk({tag, "_i1"}, i1o, 0);
  endtask

  task automatic set_pc(input int k, input logic [PW-1:0] v);
    fetchPC[k*PW +: PW] = v;
  endtask

  task automatic drive_random();
    for (int k = 0; k < N; k++) begin
      flush[k] = 1'b0;
      if (fv[k]) fetchReq[k] = 1'b0;
      else if ($urandom_range(0, 39) == 0) begin
        flush[k] = 1'b1; fetchReq[k] = 1'b0;
      end else if (!fetchReq[k] && $urandom_range(0, 2) == 0) begin
        fetchReq[k] = 1'b1; set_pc(k, $urandom);
      end
    end
    cacheAck   = 1'($urandom_range(0, 1));
    cacheValid = ($urandom_range(0, 2) == 0);
    i0i = {$urandom, $urandom};
    i1i = {$urandom, $urandom};
  endtask

  initial begin
    logic [N-1:0] order [$];
    logic [N-1:0] last;
    reset = 1'b0; fetchReq = '0; flush = '0; fetchPC = '0;
    cacheAck = 0; cacheValid = 0; i0i = '0; i1i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;

    // Single request from SM0.
    fetchReq = 4'b0001; set_pc(0, 32'h100);
    step();
    chk("t1_req_latency", cacheReq, 1);
    chk("t1_pc", PCo, 32'h100);
    chk("t1_pc1", PC1o, 32'h101);
    cacheAck = 1; step();
    chk("t1_wait_noreq", cacheReq, 0);
    cacheAck = 0; step();
    cacheValid = 1; i0i = 64'hAAAA_0000_1111_2222; i1i = 64'hBBBB_3333_4444_5555;
    step();
    chk("t1_fv", fv, 4'b0001);
    chk("t1_i0", i0o, 64'hAAAA_0000_1111_2222);
    chk("t1_i1", i1o, 64'hBBBB_3333_4444_5555);
    cacheValid = 0; fetchReq = '0;
    step();
    chk("t1_fv_pulse", fv, 4'b0000);

    // Reset while waiting for SM2's response.
    fetchReq = 4'b0100; set_pc(2, 32'h300);
    step();
    cacheAck = 1; step();
    cacheAck = 0;
    chk("rst_in_wait", busy, 1);
    reset = 1'b0; #1;
    chk_all_zero("rst_mid");
    model_reset();
    fetchReq = '0;
    #1 reset = 1'b1;

    // All four requesting, immediate ack/valid: rotating grants from SM0.
    fetchReq = 4'b1111;
    for (int k = 0; k < N; k++) set_pc(k, 32'h1000 * (k + 1));
    cacheAck = 1; cacheValid = 1;
    last = '0;
    for (int c = 0; c < 16; c++) begin
      step();
`ifdef ICACHE_ARB_B2B_EN
      chk("b2b_busy", busy, 1);
`endif
      if (grant != 0 && grant != last) begin
        order.push_back(grant);
        last = grant;
      end
    end
    chk("rr_count_ok", order.size() >= 5, 1);
    if (order.size() >= 5) begin
      chk("rr0", order[0], 4'b0001);
      chk("rr1", order[1], 4'b0010);
      chk("rr2", order[2], 4'b0100);
      chk("rr3", order[3], 4'b1000);
      chk("rr4", order[4], 4'b0001);
    end
    fetchReq = '0;
    repeat (6) step();
    cacheAck = 0; cacheValid = 0;
    step();

    // Ack held low for 5 cycles.
    fetchReq = 4'b0010; set_pc(1, 32'h2000);
    step();
    for (int c = 0; c < 5; c++) begin
      chk("stall_req", cacheReq, 1);
      chk("stall_pc", PCo, 32'h2000);
      step();
    end
    cacheAck = 1; step();
    chk("stall_wait_busy", busy, 1);
    chk("stall_wait_req", cacheReq, 0);
    cacheAck = 0; cacheValid = 1; step();
    chk("stall_fv", fv, 4'b0010);
    cacheValid = 0; fetchReq = '0; step();

    // Flush SM2 during WAIT, coincident with valid: no delivery, SM3 next.
    fetchReq = 4'b1100; set_pc(2, 32'h2200); set_pc(3, 32'h3300);
    step();
    chk("fl_grant2", grant, 4'b0100);
    cacheAck = 1; step();
    cacheAck = 0;
    flush = 4'b0100; fetchReq = 4'b1000; cacheValid = 1;
    step();
    chk("fl_no_fv", fv, 4'b0000);
    flush = '0; cacheValid = 0;
    step();
    chk("fl_no_fv2", fv, 4'b0000);
    chk("fl_next_sm3", grant, 4'b1000);
    cacheAck = 1; step();
    cacheAck = 0; cacheValid = 1; step();
    chk("fl_sm3_fv", fv, 4'b1000);
    cacheValid = 0; fetchReq = '0; step();

    // PC wrap.
    fetchReq = 4'b0001; set_pc(0, 32'hFFFF_FFFF);
    step();
    chk("wrap_pc", PCo, 32'hFFFF_FFFF);
    chk("wrap_pc1", PC1o, 32'h0000_0000);
    cacheAck = 1; step();
    cacheAck = 0; cacheValid = 1; step();
    cacheValid = 0; fetchReq = '0; step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      drive_random();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
